// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;

  // Internal frame key carries an extra "none" flag in its MSB.
  localparam logic [KEY_W:0] KEY_NONE = {1'b1, {KEY_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  function automatic logic key_is_none(input logic [KEY_W:0] k);
    return k[KEY_W];
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column drive, row synchroniser and per-frame key accumulation for a 4x4 keypad.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic             frame_end,
  output logic [KEY_W:0]   frame_key
);

  localparam int DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW_W-1:0] dwell;
  logic [1:0]      col_idx;
  logic [ROWS-1:0] row_meta;
  logic [ROWS-1:0] row_sync;
  logic [1:0]      hit_cnt;
  logic [KEY_W-1:0] hit_pos;

  logic            sample;
  logic [ROWS-1:0] row_hit;
  logic [2:0]      sample_cnt;
  logic [KEY_W-1:0] sample_code;
  logic [2:0]      total;
  logic [1:0]      total_sat;

  function automatic logic [2:0] count_rows(input logic [ROWS-1:0] r);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < ROWS; i++) n = n + {2'b00, r[i]};
    return n;
  endfunction

  function automatic logic [1:0] first_row(input logic [ROWS-1:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) if (r[i]) idx = 2'(i);
    return idx;
  endfunction

  // Two-flop synchroniser; rows are asynchronous to clock.
  always_ff @(posedge clock) begin
    row_meta <= row_n;
    row_sync <= row_meta;
  end

  assign col_n       = ~(4'd1 << col_idx);
  assign sample      = (dwell == DW_W'(SCAN_DIV - 1));
  assign row_hit     = ~row_sync;
  assign sample_cnt  = count_rows(row_hit);
  assign sample_code = {first_row(row_hit), col_idx};

  // Hit count only needs to distinguish 0, 1 and "more than one".
  always_comb begin
    total     = {1'b0, hit_cnt} + (sample ? sample_cnt : 3'd0);
    total_sat = (total >= 3'd2) ? 2'd2 : total[1:0];
  end

  assign frame_end = sample && (col_idx == 2'd3);

  always_comb begin
    frame_key = KEY_NONE;
    if (frame_end && (total_sat == 2'd1))
      frame_key = {1'b0, (hit_cnt == 2'd1) ? hit_pos : sample_code};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dwell   <= '0;
      col_idx <= 2'd0;
      hit_cnt <= 2'd0;
      hit_pos <= '0;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
      if (col_idx == 2'd3) begin
        hit_cnt <= 2'd0;
        hit_pos <= '0;
      end else begin
        hit_cnt <= total_sat;
        if ((hit_cnt == 2'd0) && (sample_cnt == 3'd1))
          hit_pos <= sample_code;
      end
    end else begin
      dwell <= dwell + DW_W'(1);
    end
  end

endmodule

// File: rtl/in_keypad.sv
// Keypad front end: frame-based debounce FSM and one-entry valid/ready key buffer.
module in_keypad
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_down,
  output logic             overrun,
  input  logic             clear_overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_FRAMES);

  logic           frame_end;
  logic [KEY_W:0] frame_key;

  state_t           state, state_next;
  logic [KEY_W-1:0] cand, cand_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic [CNT_W-1:0] rel_cnt, rel_next, rel_inc;
  logic             emit;
  logic [KEY_W-1:0] emit_code;

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clock     (clock),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .frame_end (frame_end),
    .frame_key (frame_key)
  );

  assign cnt_inc = cnt + CNT_W'(1);
  assign rel_inc = rel_cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rel_cnt <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      rel_cnt <= rel_next;
    end
  end

  always_ff @(posedge clock) cand <= cand_next;

  // Debounce decisions are taken only on the frame-end cycle.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    rel_next   = rel_cnt;
    emit       = 1'b0;
    emit_code  = cand;
    if (frame_end) begin
      case (state)
        ST_IDLE: begin
          if (!key_is_none(frame_key)) begin
            cand_next = frame_key[KEY_W-1:0];
            emit_code = frame_key[KEY_W-1:0];
            cnt_next  = CNT_W'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              emit       = 1'b1;
              state_next = ST_HELD;
              rel_next   = '0;
              cnt_next   = '0;
            end else begin
              state_next = ST_CAND;
            end
          end
        end
        ST_CAND: begin
          if (key_is_none(frame_key)) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (frame_key[KEY_W-1:0] == cand) begin
            if (cnt_inc == CNT_TOP) begin
              emit       = 1'b1;
              state_next = ST_HELD;
              rel_next   = '0;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            cand_next = frame_key[KEY_W-1:0];
            cnt_next  = CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!key_is_none(frame_key)) begin
            rel_next = '0;
          end else if (rel_inc == CNT_TOP) begin
            state_next = ST_IDLE;
            rel_next   = '0;
          end else begin
            rel_next = rel_inc;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          rel_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_down = (state == ST_HELD);
  end

  // One-entry buffer: a full, unacknowledged slot keeps its code and flags overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (emit) begin
        if (!key_valid || key_ready) begin
          key_code  <= emit_code;
          key_valid <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (emit && key_valid && !key_ready)
        overrun <= 1'b1;
      else if (clear_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_in_keypad.sv
// Directed bench for in_keypad with a behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_FRAMES=2).
module tb_in_keypad;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_down;
  logic       overrun;
  logic       clear_overrun;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;

  in_keypad #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .row_n         (row_n),
    .col_n         (col_n),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .key_down      (key_down),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clock = ~clock;

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic frames(input int n);
    step(16 * n);
  endtask

  task automatic consume();
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    step(15);
  endtask

  initial begin
    reset = 1'b1; keys = '0; key_ready = 1'b0; clear_overrun = 1'b0;
    step(3);
    reset = 1'b0;

    // Reset state and idle column rotation
    check("rst_col", col_n, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_down", key_down, 0);
    check("rst_code", key_code, 0);
    check("rst_ovr", overrun, 0);
    step(4); check("col1", col_n, 4'b1101);
    step(4); check("col2", col_n, 4'b1011);
    step(4); check("col3", col_n, 4'b0111);
    step(4); check("col0", col_n, 4'b1110);

    // Key 9 (row 2, col 1) held for three frames
    keys = 16'h1 << 9;
    frames(1); check("k9_f1_valid", key_valid, 0);
    step(15);  check("k9_pre_valid", key_valid, 0);
    step(1);   check("k9_valid", key_valid, 1);
    check("k9_code", key_code, 9);
    check("k9_down", key_down, 1);
    step(15);  check("k9_f3_ovr", overrun, 0);
    keys = '0;
    step(1);
    frames(1); check("k9_rel1_down", key_down, 1);
    frames(1); check("k9_rel2_down", key_down, 0);
    consume(); check("k9_consumed", key_valid, 0);

    // Glitchy key 9: present, absent, present, present
    keys = 16'h1 << 9; frames(1); check("gl_a", key_valid, 0);
    keys = '0;         frames(1); check("gl_b", key_valid, 0);
    keys = 16'h1 << 9; frames(1); check("gl_c", key_valid, 0);
    frames(1); check("gl_d_valid", key_valid, 1);
    check("gl_d_code", key_code, 9);
    keys = '0; frames(2); consume();
    // Two keys at once never resolve to a single key
    keys = (16'h1 << 5) | (16'h1 << 6);
    frames(3); check("multi_valid", key_valid, 0);
    check("multi_down", key_down, 0);
    keys = '0; frames(1);

    // Overrun: key 3 unconsumed, then key 7 arrives
    keys = 16'h1 << 3; frames(2);
    check("ov_k3_valid", key_valid, 1);
    check("ov_k3_code", key_code, 3);
    keys = '0; frames(2);
    keys = 16'h1 << 7; frames(2);
    check("ov_code_kept", key_code, 3);
    check("ov_flag", overrun, 1);
    keys = '0; frames(2);
    check("ov_sticky", overrun, 1);
    clear_overrun = 1'b1; key_ready = 1'b1;
    step(1);
    clear_overrun = 1'b0; key_ready = 1'b0;
    check("ov_cleared", overrun, 0);
    check("ov_consumed", key_valid, 0);
    step(15);

    // Emit on the same cycle the pending key is accepted
    keys = 16'h1 << 12; frames(2);
    check("bt_k12_code", key_code, 12);
    keys = '0; frames(2);
    keys = 16'h1 << 15; frames(1); step(15);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check("bt_valid", key_valid, 1);
    check("bt_code", key_code, 15);
    check("bt_ovr", overrun, 0);
    keys = '0; step(15); frames(2); consume();

    // Reset mid-debounce abandons the candidate
    keys = 16'h1 << 10; frames(1); step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mr_col", col_n, 4'b1110);
    check("mr_code", key_code, 0);
    check("mr_valid", key_valid, 0);
    check("mr_down", key_down, 0);
    check("mr_ovr", overrun, 0);
    frames(1); check("mr_f1_valid", key_valid, 0);
    frames(1); check("mr_f2_valid", key_valid, 1);
    check("mr_f2_code", key_code, 10);
    check("mr_f2_down", key_down, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
